// File: rtl/core_ctrl_pkg.sv
// Shared job-phase encoding for the core launch sequencer and the board status LED driver.
package core_ctrl_pkg;

  localparam logic [1:0] PH_IDLE  = 2'b00;
  localparam logic [1:0] PH_START = 2'b01;
  localparam logic [1:0] PH_WAIT  = 2'b10;
  localparam logic [1:0] PH_DONE  = 2'b11;

  localparam int unsigned NUM_CORES_DEFAULT = 4;

  // Phases during which a job is in flight
  function automatic logic phase_is_busy(input logic [1:0] ph);
    return (ph == PH_START) || (ph == PH_WAIT);
  endfunction

endpackage

// File: rtl/core_launch_watchdog.sv
// Saturating WAIT-cycle counter; flags the last permitted cycle of WAIT_FOR_DONE.
module core_launch_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expire_c
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (count_en && (count_q != CNT_MAX)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign expire_c = count_en && (count_q == CNT_LAST);

endmodule

// File: rtl/core_launch_sequencer.sv
// Launches all accelerator cores, collects done indications and reports job phase to the LED driver.
// Optional watchdog on WAIT_FOR_DONE enabled by defining CORE_LAUNCH_TIMEOUT_EN.
module core_launch_sequencer
  import core_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CORES      = NUM_CORES_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  output logic [NUM_CORES-1:0] core_start,
  input  logic [NUM_CORES-1:0] core_done,
  output logic [1:0]           phase,
  output logic                 busy,
  output logic                 done_pulse,
  output logic [NUM_CORES-1:0] done_mask,
  output logic                 timeout
);

  localparam logic [NUM_CORES-1:0] ALL_CORES = {NUM_CORES{1'b1}};

  if ((NUM_CORES < 1) || (NUM_CORES > 16) || (TIMEOUT_CYCLES < 2)) begin : g_param_check
    $error("core_launch_sequencer: NUM_CORES must be 1..16 and TIMEOUT_CYCLES >= 2");
  end

  logic [1:0]           state_q;
  logic [1:0]           state_d;
  logic [NUM_CORES-1:0] mask_d;
  logic [NUM_CORES-1:0] merged_c;
  logic                 timeout_d;
  logic                 wd_expire_c;

`ifdef CORE_LAUNCH_TIMEOUT_EN
  logic wd_clear_c;
  logic wd_count_c;

  // Counter restarts on the edge that enters WAIT_FOR_DONE
  assign wd_clear_c = (state_q == PH_START);
  assign wd_count_c = (state_q == PH_WAIT);

  core_launch_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (wd_clear_c),
    .count_en (wd_count_c),
    .expire_c (wd_expire_c)
  );
`else
  assign wd_expire_c = 1'b0;
`endif

  // Next state, mask and sticky timeout
  always_comb begin
    state_d   = state_q;
    mask_d    = done_mask;
    timeout_d = timeout;
    merged_c  = done_mask | core_done;
    case (state_q)
      PH_IDLE: begin
        if (go) begin
          state_d   = PH_START;
          mask_d    = '0;
          timeout_d = 1'b0;
        end
      end
      PH_START: begin
        state_d = PH_WAIT;
      end
      PH_WAIT: begin
        mask_d = merged_c;
        // A mask completing on the expiry cycle counts as a normal finish
        if (merged_c == ALL_CORES) begin
          state_d = PH_DONE;
        end else if (wd_expire_c) begin
          state_d   = PH_DONE;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = PH_IDLE;
      end
    endcase
  end

  // Strobes are registered from the next state so they align with the phase they mark
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PH_IDLE;
      core_start <= '0;
      busy       <= 1'b0;
      done_pulse <= 1'b0;
      done_mask  <= '0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_d;
      core_start <= (state_d == PH_START) ? ALL_CORES : '0;
      busy       <= phase_is_busy(state_d);
      done_pulse <= (state_d == PH_DONE);
      done_mask  <= mask_d;
      timeout    <= timeout_d;
    end
  end

  assign phase = state_q;

endmodule

// File: tb/tb_core_launch_sequencer.sv
// Self-checking bench for core_launch_sequencer (NUM_CORES=4, TIMEOUT_CYCLES=16).
module tb_core_launch_sequencer;

  localparam int NC = 4;
  localparam int TO = 16;
`ifdef CORE_LAUNCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic [NC-1:0] core_start;
  logic [NC-1:0] core_done;
  logic [1:0]    phase;
  logic          busy;
  logic          done_pulse;
  logic [NC-1:0] done_mask;
  logic          timeout;

  always #5 clk = ~clk;

  core_launch_sequencer #(
    .NUM_CORES      (NC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .core_start (core_start),
    .core_done  (core_done),
    .phase      (phase),
    .busy       (busy),
    .done_pulse (done_pulse),
    .done_mask  (done_mask),
    .timeout    (timeout)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: job phase number, accumulated mask, sticky timeout, WAIT cycles elapsed
  int      m_ph   = 0;
  logic [3:0] m_mask = '0;
  bit      m_to   = 1'b0;
  int      m_wait = 0;

  typedef struct {
    bit         go;
    logic [3:0] cd;
    int         ph;
    logic [3:0] mask;
    bit         pulse;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic g, input logic [3:0] cd);
    if (r) begin
      m_ph = 0; m_mask = '0; m_to = 1'b0; m_wait = 0;
    end else begin
      case (m_ph)
        0: if (g) begin m_ph = 1; m_mask = '0; m_to = 1'b0; end
        1: begin m_ph = 2; m_wait = 0; end
        2: begin
          m_wait++;
          m_mask = m_mask | cd;
          if (m_mask == 4'hF) m_ph = 3;
          else if (TO_EN && (m_wait >= TO)) begin m_ph = 3; m_to = 1'b1; end
        end
        default: m_ph = 0;
      endcase
    end
  endtask

  // One clock: capture applied inputs, advance model, sample outputs after the edge
  task automatic step();
    logic r;
    logic g;
    logic [3:0] cd;
    r = rst; g = go; cd = core_done;
    @(posedge clk);
    model_update(r, g, cd);
    #1;
  endtask

  task automatic check_model();
    chk("mdl_phase", 32'(phase), 32'(m_ph));
    chk("mdl_start", 32'(core_start), (m_ph == 1) ? 32'hF : 32'h0);
    chk("mdl_busy", 32'(busy), 32'((m_ph == 1) || (m_ph == 2)));
    chk("mdl_pulse", 32'(done_pulse), 32'(m_ph == 3));
    chk("mdl_mask", 32'(done_mask), 32'(m_mask));
    chk("mdl_timeout", 32'(timeout), 32'(m_to));
  endtask

  initial begin
    int starts;
    int pulses;

    // go, core_done, expected phase, mask, done_pulse
    tv[0]  = '{1'b1, 4'b0000, 1, 4'b0000, 1'b0};
    tv[1]  = '{1'b0, 4'b1111, 2, 4'b0000, 1'b0};
    tv[2]  = '{1'b0, 4'b0001, 2, 4'b0001, 1'b0};
    tv[3]  = '{1'b0, 4'b0100, 2, 4'b0101, 1'b0};
    tv[4]  = '{1'b0, 4'b1000, 2, 4'b1101, 1'b0};
    tv[5]  = '{1'b0, 4'b0010, 3, 4'b1111, 1'b1};
    tv[6]  = '{1'b0, 4'b0000, 0, 4'b1111, 1'b0};
    tv[7]  = '{1'b0, 4'b1111, 0, 4'b1111, 1'b0};
    tv[8]  = '{1'b1, 4'b0000, 1, 4'b0000, 1'b0};
    tv[9]  = '{1'b0, 4'b0000, 2, 4'b0000, 1'b0};
    tv[10] = '{1'b0, 4'b1111, 3, 4'b1111, 1'b1};
    tv[11] = '{1'b0, 4'b0000, 0, 4'b1111, 1'b0};

    rst = 1'b1; go = 1'b0; core_done = '0;
    step(); step();
    chk("rst_phase", 32'(phase), 32'h0);
    chk("rst_start", 32'(core_start), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_pulse", 32'(done_pulse), 32'h0);
    chk("rst_mask", 32'(done_mask), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      go = tv[i].go; core_done = tv[i].cd;
      step();
      chk($sformatf("tv%0d_phase", i), 32'(phase), 32'(tv[i].ph));
      chk($sformatf("tv%0d_mask", i), 32'(done_mask), 32'(tv[i].mask));
      chk($sformatf("tv%0d_pulse", i), 32'(done_pulse), 32'(tv[i].pulse));
      chk($sformatf("tv%0d_start", i), 32'(core_start), (tv[i].ph == 1) ? 32'hF : 32'h0);
      chk($sformatf("tv%0d_busy", i), 32'(busy), 32'((tv[i].ph == 1) || (tv[i].ph == 2)));
    end
    go = 1'b0; core_done = '0;

    // Reset in the middle of WAIT with a partial mask
    go = 1'b1; step(); go = 1'b0; step();
    core_done = 4'b0001; step();
    core_done = 4'b0100; step();
    chk("midwait_mask", 32'(done_mask), 32'h5);
    chk("midwait_phase", 32'(phase), 32'h2);
    core_done = '0; rst = 1'b1; step(); rst = 1'b0;
    chk("midrst_phase", 32'(phase), 32'h0);
    chk("midrst_mask", 32'(done_mask), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_start", 32'(core_start), 32'h0);
    chk("midrst_pulse", 32'(done_pulse), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("postrst_pulse", 32'(done_pulse), 32'h0);
      chk("postrst_phase", 32'(phase), 32'h0);
    end

    // go held high with immediate completion: back-to-back 4-cycle jobs
    starts = 0; pulses = 0;
    go = 1'b1; core_done = 4'hF;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("held_phase", 32'(phase), 32'(k % 4));
      if (core_start == 4'hF) starts++;
      if (done_pulse) pulses++;
    end
    chk("held_starts", 32'(starts), 32'd3);
    chk("held_pulses", 32'(pulses), 32'd3);
    go = 1'b0; core_done = '0;
    step();
    chk("held_idle", 32'(phase), 32'h0);

    // Only cores 0 and 1 report: watchdog expiry or indefinite wait
    go = 1'b1; step(); go = 1'b0; step();
    for (int k = 1; k <= TO; k++) begin
      core_done = (k == 1) ? 4'b0001 : (k == 2) ? 4'b0010 : 4'b0000;
      step();
      if (k < TO) chk("to_wait_phase", 32'(phase), 32'h2);
    end
    core_done = '0;
    if (TO_EN) begin
      chk("to_phase", 32'(phase), 32'h3);
      chk("to_flag", 32'(timeout), 32'h1);
      chk("to_mask", 32'(done_mask), 32'h3);
      chk("to_pulse", 32'(done_pulse), 32'h1);
      step();
      chk("to_sticky", 32'(timeout), 32'h1);
      go = 1'b1; step(); go = 1'b0;
      chk("to_cleared", 32'(timeout), 32'h0);
      chk("to_mask_clr", 32'(done_mask), 32'h0);
      step();
      for (int k = 1; k <= TO; k++) begin
        core_done = (k == 1) ? 4'b0111 : (k == TO) ? 4'b1000 : 4'b0000;
        step();
      end
      core_done = '0;
      chk("race_phase", 32'(phase), 32'h3);
      chk("race_timeout", 32'(timeout), 32'h0);
      chk("race_mask", 32'(done_mask), 32'hF);
      step();
    end else begin
      for (int k = 0; k < 30; k++) begin
        step();
        chk("nowd_phase", 32'(phase), 32'h2);
        chk("nowd_timeout", 32'(timeout), 32'h0);
      end
      core_done = 4'b1100; step();
      chk("nowd_done", 32'(phase), 32'h3);
      core_done = '0; step();
    end
    chk("seq_idle", 32'(phase), 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      go = ($urandom_range(0, 3) == 0);
      core_done = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      step();
      check_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
